// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int unsigned PIPE_AW = 4;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic               valid;
    logic [PIPE_AW-1:0] dst;
    logic               wr_en;
    logic               is_load;
  } stage_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between decode and the controller.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned AW      = PIPE_AW,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                   id_valid;
  logic [NUM_SRC*AW-1:0]  id_src;
  logic [NUM_SRC-1:0]     id_src_used;
  logic [AW-1:0]          id_dst;
  logic                   id_wr_en;
  logic                   id_is_load;
  logic                   branch_taken;
  logic                   ext_stall;

  logic                   stall_if_id;
  logic                   bubble_ex;
  logic                   flush_if_id;
  logic                   flush_id_ex;
  logic                   freeze_all;
  logic [NUM_SRC*2-1:0]   fwd_sel;
  logic [NUM_SRC-1:0]     id_wb_bypass;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_wr_en, id_is_load, branch_taken, ext_stall,
    input  stall_if_id, bubble_ex, flush_if_id, flush_id_ex, freeze_all, fwd_sel, id_wb_bypass,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_wr_en, id_is_load, branch_taken, ext_stall,
    output stall_if_id, bubble_ex, flush_if_id, flush_id_ex, freeze_all, fwd_sel, id_wb_bypass,
           stall_cnt
  );
endinterface

// File: rtl/pipe_match.sv
// Producer/consumer register match for one stage entry; PIPE_ZERO_REG_EN makes r0 never match.
module pipe_match
  import pipe_pkg::*;
(
  input  stage_entry_t       entry,
  input  logic [PIPE_AW-1:0] addr,
  output logic               hit
);

  always_comb begin
    hit = entry.valid && entry.wr_en && (entry.dst == addr);
`ifdef PIPE_ZERO_REG_EN
    if (addr == '0) hit = 1'b0;
`endif
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller tracking EX/MEM/WB shadow entries.
// Optional build macro PIPE_ZERO_REG_EN hardwires r0 (handled in pipe_match).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned AW      = PIPE_AW,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic               Clk,
  input logic               Rst,
  pipe_hazard_ctrl_if.slave bus
);

  stage_entry_t          ex_q, ex_d, mem_q, wb_q;
  logic [NUM_SRC*AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]    ex_src_used_q, ex_src_used_d;
  logic [CNT_W-1:0]      stall_cnt_q;

  logic [NUM_SRC-1:0]    hit_ex_id, hit_mem_ex, hit_wb_ex, hit_wb_id;
  logic                  load_use;
  logic                  stall_if_id, bubble_ex, flush_if_id, flush_id_ex, freeze_all;
  logic [NUM_SRC*2-1:0]  fwd_sel;
  logic [NUM_SRC-1:0]    id_wb_bypass;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    pipe_match u_ex_id  (.entry(ex_q),  .addr(bus.id_src[k*AW +: AW]), .hit(hit_ex_id[k]));
    pipe_match u_mem_ex (.entry(mem_q), .addr(ex_src_q[k*AW +: AW]),   .hit(hit_mem_ex[k]));
    pipe_match u_wb_ex  (.entry(wb_q),  .addr(ex_src_q[k*AW +: AW]),   .hit(hit_wb_ex[k]));
    pipe_match u_wb_id  (.entry(wb_q),  .addr(bus.id_src[k*AW +: AW]), .hit(hit_wb_id[k]));
  end

  assign load_use = bus.id_valid && ex_q.is_load && |(bus.id_src_used & hit_ex_id);

  // Everything combinational is held at zero while Rst is high.
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_all   = 1'b0;
    fwd_sel      = '0;
    id_wb_bypass = '0;
    if (!Rst) begin
      if (bus.ext_stall) begin
        freeze_all = 1'b1;
      end else if (bus.branch_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
        // A load in MEM is never a forwarding source; load_use keeps it out of reach.
        if (ex_q.valid && ex_src_used_q[k] && hit_mem_ex[k] && !mem_q.is_load) begin
          fwd_sel[k*2 +: 2] = FWD_MEM;
        end else if (ex_q.valid && hit_wb_ex[k]) begin
          fwd_sel[k*2 +: 2] = FWD_WB;
        end
        id_wb_bypass[k] = bus.id_valid && bus.id_src_used[k] && hit_wb_id[k];
      end
    end
  end

  always_comb begin
    ex_d          = '0;
    ex_src_d      = '0;
    ex_src_used_d = '0;
    if (bus.id_valid && !bus.branch_taken && !load_use) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = bus.id_dst;
      ex_d.wr_en    = bus.id_wr_en;
      ex_d.is_load  = bus.id_is_load;
      ex_src_d      = bus.id_src;
      ex_src_used_d = bus.id_src_used;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ex_src_q      <= '0;
      ex_src_used_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (!bus.ext_stall) begin
        wb_q          <= mem_q;
        mem_q         <= ex_q;
        ex_q          <= ex_d;
        ex_src_q      <= ex_src_d;
        ex_src_used_q <= ex_src_used_d;
      end
      if ((stall_if_id || freeze_all) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_if_id  = stall_if_id;
  assign bus.bubble_ex    = bubble_ex;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.freeze_all   = freeze_all;
  assign bus.fwd_sel      = fwd_sel;
  assign bus.id_wb_bypass = id_wb_bypass;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW      = 4;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned CNT_W   = 16;
`ifdef PIPE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef struct {
    bit valid;
    int dst;
    bit wr;
    bit ld;
  } instr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  pipe_hazard_ctrl_if #(.AW(AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.AW(AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; operands of the EX instruction kept aside.
  instr_t pipe [3];
  int     ex_src  [NUM_SRC];
  bit     ex_used [NUM_SRC];
  int     cnt;

  function automatic bit produces(instr_t e, int a);
    if (ZeroReg && a == 0) return 1'b0;
    return e.valid && e.wr && e.dst == a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{valid: 1'b0, dst: 0, wr: 1'b0, ld: 1'b0};
    for (int k = 0; k < NUM_SRC; k++) begin
      ex_src[k]  = 0;
      ex_used[k] = 1'b0;
    end
    cnt = 0;
  endtask

  // One cycle: apply ID/control inputs, compare all outputs, clock, advance the model.
  task automatic step(input bit r, input bit v, input int s0, input int s1, input int used,
                      input int d, input bit w, input bit l, input bit br, input bit ext);
    int  srcs [NUM_SRC];
    bit  lu, stall, freeze, flush;
    logic [31:0] e_fwd, e_byp;
    srcs[0] = s0;
    srcs[1] = s1;
    rst              = r;
    bus.id_valid     = v;
    bus.id_src       = {AW'(s1), AW'(s0)};
    bus.id_src_used  = NUM_SRC'(used);
    bus.id_dst       = AW'(d);
    bus.id_wr_en     = w;
    bus.id_is_load   = l;
    bus.branch_taken = br;
    bus.ext_stall    = ext;
    #1;
    lu = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (v && used[k] && pipe[0].ld && produces(pipe[0], srcs[k])) lu = 1'b1;
    freeze = !r && ext;
    flush  = !r && !ext && br;
    stall  = !r && !ext && !br && lu;
    e_fwd = 0;
    e_byp = 0;
    if (!r) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (pipe[0].valid && ex_used[k] && produces(pipe[1], ex_src[k]) && !pipe[1].ld)
          e_fwd[k*2 +: 2] = 2'd1;
        else if (pipe[0].valid && produces(pipe[2], ex_src[k]))
          e_fwd[k*2 +: 2] = 2'd2;
        e_byp[k] = v && used[k] && produces(pipe[2], srcs[k]);
      end
    end
    check_eq("freeze_all",   32'(bus.freeze_all),   32'(freeze));
    check_eq("flush_if_id",  32'(bus.flush_if_id),  32'(flush));
    check_eq("flush_id_ex",  32'(bus.flush_id_ex),  32'(flush));
    check_eq("stall_if_id",  32'(bus.stall_if_id),  32'(stall));
    check_eq("bubble_ex",    32'(bus.bubble_ex),    32'(stall));
    check_eq("fwd_sel",      32'(bus.fwd_sel),      e_fwd);
    check_eq("id_wb_bypass", 32'(bus.id_wb_bypass), e_byp);
    check_eq("stall_cnt",    32'(bus.stall_cnt),    32'(cnt));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if ((stall || freeze) && cnt < (1 << CNT_W) - 1) cnt++;
      if (!ext) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (br || lu || !v) begin
          pipe[0] = '{valid: 1'b0, dst: 0, wr: 1'b0, ld: 1'b0};
        end else begin
          pipe[0] = '{valid: 1'b1, dst: d, wr: w, ld: l};
          for (int k = 0; k < NUM_SRC; k++) begin
            ex_src[k]  = srcs[k];
            ex_used[k] = used[k];
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    bit held_br;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_src = '0; bus.id_src_used = '0; bus.id_dst = '0;
    bus.id_wr_en = 1'b0; bus.id_is_load = 1'b0; bus.branch_taken = 1'b0; bus.ext_stall = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use: ld r3; add r5=r3+r1 stalls once; then drains with WB forward.
    step(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    step(0, 1, 3, 1, 3, 5, 1, 0, 0, 0);
    step(0, 1, 3, 1, 3, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU forwarding: r4 then r2 producers, consumer reads r2/r4; then same dst in MEM and WB.
    step(0, 1, 0, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 2, 4, 3, 6, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 2, 2, 3, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Branch alongside load-use, then WB bypass on r7 and on r0.
    step(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    step(0, 1, 3, 0, 1, 5, 1, 0, 1, 0);
    step(0, 1, 7, 0, 1, 7, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 0, 3, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);

    // ext_stall for 3 cycles during a load-use, then the single stall cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    repeat (3) step(0, 1, 3, 1, 1, 5, 1, 0, 0, 1);
    step(0, 1, 3, 1, 1, 5, 1, 0, 0, 0);
    check_eq("stall_cnt_after_freeze", 32'(bus.stall_cnt), 32'd4);
    // Reset mid-stall.
    step(0, 1, 3, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 3, 0, 1, 5, 1, 0, 0, 0);
    step(0, 1, 3, 3, 3, 5, 1, 0, 0, 0);

    held_br = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit ext, br;
      ext = ($urandom_range(0, 99) < 12);
      br  = held_br || ($urandom_range(0, 99) < 10);
      held_br = br && ext;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 5)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
           br, ext);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB processor pipeline.
- Keeps shadow copies of the destination and source information for each in-flight instruction.
- Detects load-use hazards and resolves data hazards by forwarding.
- Sequences branch flushes and external memory stalls, replacing ad-hoc buffer muxing with one registered control point between decode and execute.

Parameters:
- AW, 4, register-address width (2**AW architectural registers).
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- id_valid  in  1  instruction present in ID.
- id_src  in  NUM_SRC*AW  ID source register addresses; operand k at [k*AW +: AW].
- id_src_used  in  NUM_SRC  source k is actually read.
- id_dst  in  AW  ID destination register.
- id_wr_en  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a memory load.
- branch_taken  in  1  branch or jump resolved taken in EX.
- ext_stall  in  1  memory not ready; freeze the whole pipeline.
- stall_if_id  out  1  hold PC and the IF/ID buffer.
- bubble_ex  out  1  load NOP into the ID/EX buffer.
- flush_if_id  out  1  discard the IF/ID buffer.
- flush_id_ex  out  1  discard the ID/EX buffer.
- freeze_all  out  1  hold every pipeline buffer.
- fwd_sel  out  NUM_SRC*2  EX operand source: 0 = regfile, 1 = MEM-stage result, 2 = WB-stage result, 3 = reserved.
- id_wb_bypass  out  NUM_SRC  ID source k matches the WB write this cycle; use WB data instead of the regfile read.
- stall_cnt  out  CNT_W  count of cycles with stall_if_id or freeze_all asserted; saturating.

Behaviour:
- State: three registered stage entries, EX, MEM and WB.
  - Each entry holds {valid, dst, wr_en, is_load}.
  - The EX entry also holds src[] and src_used[].
- Reset (Rst=1 at a posedge): all entries invalid and stall_cnt = 0. All outputs are 0 during and after reset until inputs dictate otherwise. Reset mid-stall or mid-flush simply clears the state.
- Match(entry, a): entry.valid && entry.wr_en && entry.dst == a.
- load_use = id_valid && any k where id_src_used[k] && Match(EX, id_src[k]) && EX.is_load.
- Output priority (combinational from inputs and registered state):
  1. ext_stall: freeze_all = 1; all other control outputs 0; entries hold.
  2. branch_taken: flush_if_id = 1 and flush_id_ex = 1; load_use is ignored.
  3. load_use: stall_if_id = 1 and bubble_ex = 1.
  4. Otherwise all control outputs are 0.
- Entry update at each posedge, when not frozen:
  - WB <= MEM; MEM <= EX.
  - EX <= invalid if branch_taken, load_use or !id_valid; otherwise EX <= the ID fields.
- fwd_sel[k] is computed from the EX entry:
  - 1 if EX.src_used[k] && Match(MEM, EX.src[k]) && !MEM.is_load;
  - else 2 if Match(WB, EX.src[k]);
  - else 0.
  - MEM wins over WB (youngest producer).
  - A load in MEM never forwards; load_use guarantees it has reached WB by then.
- id_wb_bypass[k] = id_valid && id_src_used[k] && Match(WB, id_src[k]).
- Latency:
  - Hazard outputs are valid in the same cycle as the ID inputs.
  - The bubble appears in the EX entry one cycle later.
  - A load-use stall lasts exactly 1 cycle unless ext_stall extends it.
- Simultaneous events:
  - branch_taken together with ext_stall: the flush is deferred. Upstream must hold branch_taken until ext_stall falls.
  - Back-to-back load-use on consecutive instructions: each stalls 1 cycle.
- stall_cnt increments by 1 on each posedge with (stall_if_id | freeze_all) and saturates at all-ones.

Optional Feature:
- Macro: PIPE_ZERO_REG_EN.
- Defined: register address 0 is hardwired zero. Match() is forced false for a == 0, so there are no stalls, forwards or bypasses on r0.
- Undefined: r0 is treated like any other register.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2;
  - typedef stage_entry_t {valid, dst, wr_en, is_load};
  - the AW default.
- One sub-module, pipe_match:
  - combinational comparator taking an entry and an address, returning the match bit;
  - contains the PIPE_ZERO_REG_EN gating;
  - instantiated per stage × source.

Test Plan:
- Load-use: load r3 in EX, ID add r5 = r3 + r1 -> stall_if_id = 1 and bubble_ex = 1 for 1 cycle; next cycle add reaches EX; following cycle fwd_sel[0] = 2 (load in WB).
- ALU forward: add r2 in MEM, add r4 in WB, EX instruction reads r2 and r4 -> fwd_sel = {2'd2, 2'd1}; same dst r2 in both MEM and WB -> 1 (MEM wins).
- Branch flush: branch_taken = 1 alongside a load_use condition -> flush_if_id = 1, flush_id_ex = 1, stall_if_id = 0; next cycle EX entry invalid and fwd_sel = 0.
- ext_stall held 3 cycles during a load-use -> freeze_all = 1 for 3 cycles with entries unchanged; then 1 stall cycle; stall_cnt = 4.
- WB bypass: WB writes r7 while ID reads r7 -> id_wb_bypass[k] = 1; with PIPE_ZERO_REG_EN and r0 -> 0.
- Rst asserted mid-stall -> all outputs 0 and stall_cnt = 0 on the next edge; no stale forwards afterwards.
